// File: rtl/outport_scheduler.sv
// outport_scheduler: wormhole output-port arbiter with per-VC downstream credits.
// Round-robin picks an owner among requesters whose VC has credit; the owner
// keeps the port until its tail flit is accepted downstream.
// Optional watchdog: define OUTPORT_SCHED_TIMEOUT_EN to build the stall
// counter that forcibly releases a port after TIMEOUT flit-less cycles.
module outport_scheduler #(
  parameter int NUM_REQ     = 8,
  parameter int BUFFER_SIZE = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   req_vc,
  input  logic [NUM_REQ-1:0]                   req_last,
  input  logic                                 flit_sent,
  input  logic [1:0]                           credit_return,
  output logic [NUM_REQ-1:0]                   grant,
  output logic                                 grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]           sel,
  output logic [2*$clog2(BUFFER_SIZE+1)-1:0]   credits,
  output logic                                 locked,
  output logic                                 err,
  output logic                                 timeout
);

  localparam int CW = $clog2(BUFFER_SIZE+1);
  localparam int SW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUFFER_SIZE);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SW-1:0]          r_rr_ptr;
  logic [SW-1:0]          r_owner;
  logic                   r_owner_vc;
  logic                   r_err;
  logic [SW-1:0]          w_pick;
  logic                   w_pick_found;
  logic [SW:0]            w_sum;
  logic [NUM_REQ-1:0]     w_eligible;
  logic [1:0][CW-1:0]     w_cred;
  logic [1:0]             w_cred_avail;
  logic [1:0]             w_overflow;
  logic                   w_owner_ok;
  logic                   w_sent;
  logic                   w_tail_sent;
  logic                   w_timeout_fire;

  // A zero TIMEOUT would make the watchdog compare underflow; this empty
  // marker block also keeps the parameter referenced when the watchdog is off.
  if (TIMEOUT < 1) begin : g_timeout_invalid
  end

  genvar gi;

  // Requester is eligible only if its head flit's VC has downstream space.
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign w_eligible[gi] = req[gi] && w_cred_avail[req_vc[gi]];
  end

  // Round-robin search: first eligible index at or after the pointer, wrapping.
  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    w_sum        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(NUM_REQ)) w_sum = w_sum - (SW+1)'(NUM_REQ);
      if (!w_pick_found && w_eligible[w_sum[SW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick       = w_sum[SW-1:0];
      end
    end
  end

  // The owner is only granted while it requests and its VC has credit.
  assign w_owner_ok  = (r_state == ST_BUSY) && req[r_owner] && w_cred_avail[r_owner_vc];
  assign w_sent      = flit_sent && w_owner_ok;
  assign w_tail_sent = w_sent && req_last[r_owner];

  // One-hot grant driven from the owner index.
  always_comb begin
    grant          = '0;
    grant[r_owner] = w_owner_ok;
  end

  assign grant_valid = w_owner_ok;
  assign locked      = (r_state == ST_BUSY);
  assign sel         = (r_state == ST_BUSY) ? r_owner : '0;
  assign credits     = w_cred;
  assign err         = r_err;

  // Next-state: lock on a successful pick, release on tail or watchdog.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_found) w_state_next = ST_BUSY;
      ST_BUSY: if (w_tail_sent || w_timeout_fire) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any lock immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Capture owner and advance the round-robin pointer past it on each win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= '0;
      r_owner_vc <= 1'b0;
      r_rr_ptr   <= '0;
    end else if (r_state == ST_IDLE && w_pick_found) begin
      r_owner    <= w_pick;
      r_owner_vc <= req_vc[w_pick];
      r_rr_ptr   <= (w_pick == SW'(NUM_REQ-1)) ? '0 : w_pick + 1'b1;
    end
  end

  // Per-VC credit counters: send consumes, return refills, both cancel out.
  for (gi = 0; gi < 2; gi++) begin : g_cred
    logic [CW-1:0] r_cnt;
    logic          w_inc;
    logic          w_dec;

    assign w_inc = credit_return[gi];
    assign w_dec = w_sent && (r_owner_vc == 1'(gi));

    // Saturating counter; a return into a full buffer is dropped.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= CRED_MAX;
      end else if (w_inc && !w_dec) begin
        if (r_cnt != CRED_MAX) r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_cred[gi]       = r_cnt;
    assign w_cred_avail[gi] = (r_cnt != '0);
    assign w_overflow[gi]   = w_inc && !w_dec && (r_cnt == CRED_MAX);
  end

  // Sticky error: credit overflow, send without grant, or forced release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if ((|w_overflow) || (flit_sent && !w_owner_ok) || w_timeout_fire) r_err <= 1'b1;
  end

`ifdef OUTPORT_SCHED_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;

  logic [TW-1:0] r_timer;
  logic          r_timeout;

  // Fire on the stall cycle that would bring the counter to TIMEOUT.
  assign w_timeout_fire = (r_state == ST_BUSY) && !flit_sent && (r_timer == TW'(TIMEOUT-1));
  assign timeout        = r_timeout;

  // Stall counter: runs while locked without traffic, cleared by any send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_state != ST_BUSY || flit_sent || w_timeout_fire) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Timeout pulse lines up with the first cycle after the forced release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_timeout_fire;
  end
`else
  assign w_timeout_fire = 1'b0;
  assign timeout        = 1'b0;
`endif

endmodule
